// File: rtl/por_rst_seq.sv
// Ordered release of NUM_RST active-low reset domains after POR,
// with a software-reset handshake that reruns the sequence.
module por_rst_seq #(
  parameter int NUM_RST     = 4,
  parameter int DLY_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               osc_ck,
  input  logic               porb,
  input  logic [DLY_W-1:0]   dly_cfg,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_RST-1:0] rstb_out,
  output logic               seq_done,
  output logic [1:0]         seq_state
);

  localparam int IW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_RST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RUN  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [NUM_RST-1:0] rstb_q, rstb_d;
  logic               pend_q, pend_d;
  logic               ack_q, ack_d;
  logic               sync_rdy;

  // Release edge of porb is resynchronised; assertion stays asynchronous.
  always_ff @(posedge osc_ck or negedge porb) begin
    if (!porb) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_rdy = sync_q[SYNC_STAGES-1];

  always_ff @(posedge osc_ck or negedge porb) begin
    if (!porb) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      rstb_q  <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      rstb_q  <= rstb_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    rstb_d  = rstb_q;
    pend_d  = pend_q;
    ack_d   = ack_q;
    unique case (state_q)
      S_IDLE: begin
        if (sync_rdy) begin
          dly_d   = dly_cfg;
          cnt_d   = dly_cfg;
          idx_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rstb_d[idx_q] = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_RUN;
            if (pend_q) begin
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = dly_q;
          end
        end
      end
      S_RUN: begin
        // A held request is not re-armed until ack has been withdrawn.
        if (sw_rst_req && !ack_q) begin
          rstb_d  = '0;
          dly_d   = dly_cfg;
          cnt_d   = dly_cfg;
          idx_d   = '0;
          pend_d  = 1'b1;
          state_d = S_WAIT;
        end else if (!sw_rst_req) begin
          ack_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rstb_out   = rstb_q;
  assign sw_rst_ack = ack_q;
  assign seq_done   = (state_q == S_RUN);
  assign seq_state  = state_q;

endmodule

// File: tb/tb_por_rst_seq.sv
// Bench for por_rst_seq: release-edge tables, handshake sequences
// and randomised traffic against an arithmetic release-time model.
module tb_por_rst_seq;

  localparam int NUM_RST     = 4;
  localparam int DLY_W       = 8;
  localparam int SYNC_STAGES = 2;

  logic               clk;
  logic               porb;
  logic [DLY_W-1:0]   dly;
  logic               req;
  logic               ack;
  logic [NUM_RST-1:0] rstb;
  logic               done;
  logic [1:0]         st;

  por_rst_seq #(
    .NUM_RST    (NUM_RST),
    .DLY_W      (DLY_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .osc_ck    (clk),
    .porb      (porb),
    .dly_cfg   (dly),
    .sw_rst_req(req),
    .sw_rst_ack(ack),
    .rstb_out  (rstb),
    .seq_done  (done),
    .seq_state (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;

  // Reference: release times derived from start edge S and gap D.
  bit m_started, m_done, m_ack, m_pend;
  int m_S, m_D;

  int rise [NUM_RST];
  int done_e;

  typedef struct {
    logic [DLY_W-1:0] d;
    int               t [NUM_RST];
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, ecnt, act, exp);
    end
  endtask

  function automatic int nrel(input int n);
    int c;
    if (!m_started || n < m_S + 1 + m_D) return 0;
    c = (n - m_S - 1 - m_D) / (m_D + 1) + 1;
    return (c > NUM_RST) ? NUM_RST : c;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_done    = 0;
    m_ack     = 0;
    m_pend    = 0;
    m_S       = 0;
    m_D       = 0;
    ecnt      = 0;
  endtask

  task automatic model_edge();
    bit dp;
    dp = m_done;
    if (ecnt == SYNC_STAGES + 1) begin
      m_started = 1;
      m_S       = ecnt;
      m_D       = int'(dly);
    end
    if (dp) begin
      if (req && !m_ack) begin
        m_S    = ecnt;
        m_D    = int'(dly);
        m_pend = 1;
      end else if (!req) begin
        m_ack = 0;
      end
    end
    m_done = (nrel(ecnt) == NUM_RST);
    if (m_done && !dp && m_pend) begin
      m_ack  = 1;
      m_pend = 0;
    end
  endtask

  task automatic step();
    logic [NUM_RST-1:0] er;
    logic [1:0]         es;
    @(posedge clk);
    ecnt++;
    model_edge();
    @(negedge clk);
    er = NUM_RST'((1 << nrel(ecnt)) - 1);
    es = !m_started ? 2'b00 : (m_done ? 2'b10 : 2'b01);
    chk("rstb_out", 32'(rstb), 32'(er));
    chk("seq_done", 32'(done), 32'(m_done));
    chk("seq_state", 32'(st), 32'(es));
    chk("sw_rst_ack", 32'(ack), 32'(m_ack));
  endtask

  // Called just after a falling clock edge.
  task automatic por_pulse();
    #2 porb = 1'b0;
    #1;
    chk("async rstb", 32'(rstb), 32'd0);
    chk("async done", 32'(done), 32'd0);
    chk("async ack", 32'(ack), 32'd0);
    chk("async state", 32'(st), 32'd0);
    model_reset();
    @(negedge clk);
    porb = 1'b1;
  endtask

  task automatic run_seq(input int budget, input int chg_at,
                         input logic [DLY_W-1:0] d2);
    for (int k = 0; k < NUM_RST; k++) rise[k] = -1;
    done_e = -1;
    for (int i = 0; i < budget && done_e < 0; i++) begin
      if (ecnt == chg_at) dly = d2;
      step();
      for (int k = 0; k < NUM_RST; k++)
        if (rise[k] < 0 && rstb[k]) rise[k] = ecnt;
      if (done_e < 0 && done) done_e = ecnt;
    end
  endtask

  task automatic chk_rises(input string nm, input int t0, input int t1,
                           input int t2, input int t3);
    chk({nm, " bit0"}, 32'(rise[0]), 32'(t0));
    chk({nm, " bit1"}, 32'(rise[1]), 32'(t1));
    chk({nm, " bit2"}, 32'(rise[2]), 32'(t2));
    chk({nm, " bit3"}, 32'(rise[3]), 32'(t3));
    chk({nm, " done"}, 32'(done_e), 32'(t3));
  endtask

  task automatic wait_ack(input int budget, output int edge_n);
    edge_n = -1;
    for (int i = 0; i < budget && edge_n < 0; i++) begin
      step();
      if (ack) edge_n = ecnt;
    end
  endtask

  initial begin
    int e0, ea;
    porb = 1'b0;
    req  = 1'b0;
    dly  = 8'd3;
    model_reset();

    vt[0].d = 8'd3;   vt[0].t = '{7, 11, 15, 19};
    vt[1].d = 8'd0;   vt[1].t = '{4, 5, 6, 7};
    vt[2].d = 8'd1;   vt[2].t = '{5, 7, 9, 11};
    vt[3].d = 8'd255; vt[3].t = '{259, 515, 771, 1027};

    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      dly = vt[v].d;
      por_pulse();
      run_seq(1200, -1, 8'd0);
      chk_rises("table", vt[v].t[0], vt[v].t[1], vt[v].t[2], vt[v].t[3]);
    end

    // Software handshake from RUN.
    dly = 8'd3;
    por_pulse();
    run_seq(40, -1, 8'd0);
    req = 1'b1;
    step();
    e0 = ecnt;
    chk("sw accept rstb", 32'(rstb), 32'd0);
    wait_ack(100, ea);
    chk("sw ack latency", 32'(ea - e0), 32'd16);
    chk("sw ack rstb", 32'(rstb), 32'hF);
    repeat (8) step();
    chk("no retrigger rstb", 32'(rstb), 32'hF);
    chk("no retrigger ack", 32'(ack), 32'd1);
    req = 1'b0;
    step();
    chk("ack drop", 32'(ack), 32'd0);

    // porb pulse after bit 1 released.
    por_pulse();
    while (ecnt < 13) step();
    por_pulse();
    run_seq(40, -1, 8'd0);
    chk_rises("porb midwait", 7, 11, 15, 19);

    // porb pulse mid-handshake loses the ack.
    req = 1'b1;
    repeat (6) step();
    req = 1'b0;
    por_pulse();
    run_seq(40, -1, 8'd0);
    chk_rises("porb midhs", 7, 11, 15, 19);
    repeat (4) step();
    chk("porb midhs ack", 32'(ack), 32'd0);

    // dly_cfg change mid-sequence is ignored.
    dly = 8'd3;
    por_pulse();
    run_seq(60, 8, 8'd10);
    chk_rises("dly change", 7, 11, 15, 19);

    // Request held through POR sequence is a fresh request at RUN.
    dly = 8'd3;
    req = 1'b1;
    por_pulse();
    run_seq(40, -1, 8'd0);
    chk("early req done", 32'(done_e), 32'd19);
    chk("early req ack", 32'(ack), 32'd0);
    step();
    chk("early req rstb", 32'(rstb), 32'd0);
    chk("early req state", 32'(st), 32'd1);
    wait_ack(100, ea);
    chk("early req ack edge", 32'(ea), 32'd36);
    req = 1'b0;
    step();

    // Randomised traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      dly = DLY_W'($urandom_range(0, 5));
      if (r == 0) por_pulse();
      else req = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 15)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
